dram_cmd_issuer: RTL and testbench

Consumes one mapped memory request (trace entry after address mapping) and emits the closed-page DDR5 command sequence for it: ACT, RD or WR, then PRE. Each command goes out on a valid/ready port to the output-log writer, tagged with the DRAM-cycle timestamp at which it was accepted. Sits between the trace front end (parse plus address mapping) and the `dram.txt` command logger. It enforces tRCD, read/write-to-precharge and tRP spacing with down-counters.

---
 rtl/dram_cmd_issuer_pkg.sv | 41 ++++
 rtl/dram_cmd_issuer_wait_timer.sv | 33 +++
 rtl/dram_cmd_issuer.sv | 142 ++++++++++++++
 tb/tb_dram_cmd_issuer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_cmd_issuer_pkg.sv
// Shared types and default DDR5 timing for the closed-page command issuer.
// Address layout is MSB-first: row, col_high, bank, bank_group, channel, col_low, byte_sel.
package dram_cmd_issuer_pkg;

   typedef enum logic [1:0] {
      ACT = 2'd0,
      RD  = 2'd1,
      WR  = 2'd2,
      PRE = 2'd3
   } dram_cmd_e;

   typedef struct packed {
      logic [15:0] row;
      logic [5:0]  col_high;
      logic [1:0]  bank;
      logic [2:0]  bank_group;
      logic        channel;
      logic [3:0]  col_low;
      logic [1:0]  byte_sel;
   } add_map;

   localparam int unsigned T_RCD_DEF    = 39;
   localparam int unsigned T_RD2PRE_DEF = 18;
   localparam int unsigned T_WR2PRE_DEF = 76;
   localparam int unsigned T_RP_DEF     = 39;
   localparam int unsigned TS_W_DEF     = 64;

   localparam logic [1:0] OP_WRITE = 2'd1;

   // Bits needed to hold the largest (T-1) timer load value.
   function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/dram_cmd_issuer_wait_timer.sv
// Loadable down-counter; done_o flags the cycle whose decrement lands on zero,
// so the state after the wait starts exactly T cycles after the load.
module wait_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/dram_cmd_issuer.sv
// Closed-page DDR5 command issuer: ACT, RD/WR, PRE per request, each tagged with
// the free-running DRAM-cycle timestamp; tRCD / rd,wr-to-pre / tRP spacing enforced.
module dram_cmd_issuer
   import dram_cmd_issuer_pkg::*;
#(
   parameter int unsigned T_RCD    = T_RCD_DEF,
   parameter int unsigned T_RD2PRE = T_RD2PRE_DEF,
   parameter int unsigned T_WR2PRE = T_WR2PRE_DEF,
   parameter int unsigned T_RP     = T_RP_DEF,
   parameter int unsigned TS_W     = TS_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  add_map          req_add,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output dram_cmd_e       cmd_type,
   output logic [2:0]      cmd_bg,
   output logic [1:0]      cmd_bank,
   output logic [15:0]     cmd_row,
   output logic [9:0]      cmd_col,
   output logic [TS_W-1:0] cmd_time
);

   localparam int unsigned TMR_W = tmr_width(T_RCD, T_RD2PRE, T_WR2PRE, T_RP);
   localparam logic [TMR_W-1:0] LD_RCD    = TMR_W'(T_RCD - 1);
   localparam logic [TMR_W-1:0] LD_RD2PRE = TMR_W'(T_RD2PRE - 1);
   localparam logic [TMR_W-1:0] LD_WR2PRE = TMR_W'(T_WR2PRE - 1);
   localparam logic [TMR_W-1:0] LD_RP     = TMR_W'(T_RP - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACT, S_WAIT_RCD, S_COL, S_WAIT_PRE, S_PRE, S_WAIT_RP
   } state_e;

   state_e            state_q, state_d;
   add_map            add_q, add_d;
   logic [1:0]        op_q, op_d;
   logic [TS_W-1:0]   time_q, time_d;
   logic              is_wr;
   logic              col_skip;
   logic              tmr_load, tmr_dec, tmr_done;
   logic [TMR_W-1:0]  tmr_val;

   assign is_wr    = (op_q == OP_WRITE);
   // A wait of one cycle has no WAIT state: the next command follows the accept directly.
   assign col_skip = is_wr ? (T_WR2PRE == 1) : (T_RD2PRE == 1);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (req_valid && req_ready) state_d = S_ACT;
         S_ACT:      if (cmd_ready) state_d = (T_RCD == 1) ? S_COL : S_WAIT_RCD;
         S_WAIT_RCD: if (tmr_done) state_d = S_COL;
         S_COL:      if (cmd_ready) state_d = col_skip ? S_PRE : S_WAIT_PRE;
         S_WAIT_PRE: if (tmr_done) state_d = S_PRE;
         S_PRE:      if (cmd_ready) state_d = (T_RP == 1) ? S_IDLE : S_WAIT_RP;
         S_WAIT_RP:  if (tmr_done) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = rst_n && (state_q == S_IDLE);
      cmd_valid = 1'b0;
      cmd_type  = ACT;
      tmr_load  = 1'b0;
      tmr_val   = LD_RCD;
      tmr_dec   = 1'b0;
      unique case (state_q)
         S_ACT: begin
            cmd_valid = 1'b1;
            tmr_load  = cmd_ready;
         end
         S_COL: begin
            cmd_valid = 1'b1;
            cmd_type  = is_wr ? WR : RD;
            tmr_load  = cmd_ready;
            tmr_val   = is_wr ? LD_WR2PRE : LD_RD2PRE;
         end
         S_PRE: begin
            cmd_valid = 1'b1;
            cmd_type  = PRE;
            tmr_load  = cmd_ready;
            tmr_val   = LD_RP;
         end
         S_WAIT_RCD, S_WAIT_PRE, S_WAIT_RP: tmr_dec = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      add_d  = add_q;
      op_d   = op_q;
      time_d = time_q + 1'b1;
      if (req_valid && req_ready) begin
         add_d = req_add;
         op_d  = req_op;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         add_q  <= '0;
         op_q   <= '0;
         time_q <= '0;
      end else begin
         add_q  <= add_d;
         op_q   <= op_d;
         time_q <= time_d;
      end
   end

   wait_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .done_o     (tmr_done)
   );

   assign cmd_bg   = add_q.bank_group;
   assign cmd_bank = add_q.bank;
   assign cmd_row  = add_q.row;
   assign cmd_col  = {add_q.col_high, add_q.col_low};
   assign cmd_time = time_q;

   // channel and byte_sel select nothing inside a single-channel command stream.
   logic unused_add;
   assign unused_add = ^{add_q.channel, add_q.byte_sel};

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Scoreboard bench: expected ACT/RD-WR/PRE entries queued at request time and
// popped on each command handshake; a second instance runs with a 4-bit timestamp.
module tb_dram_cmd_issuer;
   import dram_cmd_issuer_pkg::*;

   typedef struct {
      dram_cmd_e        typ;
      logic [2:0]       bg;
      logic [1:0]       bank;
      logic [15:0]      row;
      logic [9:0]       col;
      longint unsigned  t;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req_valid, req_ready, cmd_valid, cmd_ready;
   logic [1:0]  req_op;
   logic [33:0] req_add;
   dram_cmd_e   cmd_type;
   logic [2:0]  cmd_bg;
   logic [1:0]  cmd_bank;
   logic [15:0] cmd_row;
   logic [9:0]  cmd_col;
   logic [63:0] cmd_time;

   logic        rst2_n, req_valid2, req_ready2, cmd_valid2, cmd_ready2;
   logic [1:0]  req_op2;
   logic [33:0] req_add2;
   dram_cmd_e   cmd_type2;
   logic [2:0]  cmd_bg2;
   logic [1:0]  cmd_bank2;
   logic [15:0] cmd_row2;
   logic [9:0]  cmd_col2;
   logic [3:0]  cmd_time2;

   dram_cmd_issuer #(
      .T_RCD(T_RCD_DEF), .T_RD2PRE(T_RD2PRE_DEF), .T_WR2PRE(T_WR2PRE_DEF),
      .T_RP(T_RP_DEF), .TS_W(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_add(req_add), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
      .cmd_col(cmd_col), .cmd_time(cmd_time)
   );

   dram_cmd_issuer #(.TS_W(4)) dut_w4 (
      .clk(clk), .rst_n(rst2_n), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_op(req_op2), .req_add(req_add2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_type(cmd_type2), .cmd_bg(cmd_bg2), .cmd_bank(cmd_bank2), .cmd_row(cmd_row2),
      .cmd_col(cmd_col2), .cmd_time(cmd_time2)
   );

   int n_chk = 0;
   int n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   longint unsigned tcyc, tcyc2;

   always @(posedge clk) begin
      if (!rst_n) tcyc <= 0; else tcyc <= tcyc + 1;
      if (!rst2_n) tcyc2 <= 0; else tcyc2 <= tcyc2 + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cmp_cmd(input string nm, input exp_t e, input dram_cmd_e typ,
                          input logic [2:0] bg, input logic [1:0] bank, input logic [15:0] row,
                          input logic [9:0] col, input logic [63:0] t, input longint unsigned tmask);
      check({nm, "_type"}, 64'(typ), 64'(e.typ));
      check({nm, "_time"}, t, e.t & tmask);
      check({nm, "_bg"}, 64'(bg), 64'(e.bg));
      check({nm, "_bank"}, 64'(bank), 64'(e.bank));
      if (e.typ == ACT) check({nm, "_row"}, 64'(row), 64'(e.row));
      else if (e.typ != PRE) check({nm, "_col"}, 64'(col), 64'(e.col));
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && cmd_valid && cmd_ready) begin
         if (q0.size() == 0) check("cmd0_without_request", 64'(q0.size()), 64'd1);
         else begin
            e = q0.pop_front();
            cmp_cmd("cmd0", e, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_time, '1);
         end
      end
      if (rst2_n && cmd_valid2 && cmd_ready2) begin
         if (q1.size() == 0) check("cmd1_without_request", 64'(q1.size()), 64'd1);
         else begin
            e = q1.pop_front();
            cmp_cmd("cmd1", e, cmd_type2, cmd_bg2, cmd_bank2, cmd_row2, cmd_col2,
                    64'(cmd_time2), 64'hF);
         end
      end
   end

   task automatic push_seq(input int d, input logic [1:0] op, input logic [33:0] a,
                           input longint unsigned t_act, input bit act_only,
                           output longint unsigned t_ready);
      exp_t e;
      longint unsigned t_col, t_pre;
      e.bg   = a[9:7];
      e.bank = a[11:10];
      e.row  = a[33:18];
      e.col  = {a[17:12], a[5:2]};
      t_col   = t_act + T_RCD_DEF;
      t_pre   = t_col + ((op == 2'd1) ? T_WR2PRE_DEF : T_RD2PRE_DEF);
      t_ready = t_pre + T_RP_DEF;
      e.typ = ACT; e.t = t_act;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      if (!act_only) begin
         e.typ = (op == 2'd1) ? WR : RD; e.t = t_col;
         if (d == 0) q0.push_back(e); else q1.push_back(e);
         e.typ = PRE; e.t = t_pre;
         if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
   endtask

   task automatic issue(input int d, input logic [1:0] op, input logic [33:0] a,
                        input int stall, input bit act_only, output longint unsigned t_ready);
      bit seen = 0;
      longint unsigned n;
      t_ready = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         seen = (d == 0) ? req_ready : req_ready2;
      end
      check("req_ready_before_issue", 64'(seen), 64'd1);
      if (!seen) return;
      n = (d == 0) ? tcyc : tcyc2;
      if (d == 0) begin
         req_op = op; req_add = a; req_valid = 1'b1; cmd_ready = (stall == 0);
      end else begin
         req_op2 = op; req_add2 = a; req_valid2 = 1'b1;
      end
      push_seq(d, op, a, n + 1 + longint'(stall), act_only, t_ready);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_valid2 = 1'b0;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("stall_act_valid", 64'(cmd_valid), 64'd1);
         check("stall_act_type", 64'(cmd_type), 64'(ACT));
         check("stall_act_row", 64'(cmd_row), 64'(a[33:18]));
         check("stall_act_bg", 64'(cmd_bg), 64'(a[9:7]));
         @(posedge clk);
      end
      if (stall > 0) begin
         #1;
         cmd_ready = 1'b1;
      end
   endtask

   task automatic wait_idle(input int d, input longint unsigned t_exp);
      bit seen = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         seen = (d == 0) ? req_ready : req_ready2;
      end
      check("ready_seen", 64'(seen), 64'd1);
      check("ready_time", (d == 0) ? tcyc : tcyc2, t_exp);
      check("sb_drained", 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
   endtask

   initial begin
      #(400_000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      longint unsigned tr;
      int nvalid;
      rst_n = 0; rst2_n = 0;
      req_valid = 0; req_op = 0; req_add = '0; cmd_ready = 1;
      req_valid2 = 0; req_op2 = 0; req_add2 = '0; cmd_ready2 = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_cmd_type", 64'(cmd_type), 64'(ACT));
      check("rst_cmd_bg", 64'(cmd_bg), 64'd0);
      check("rst_cmd_bank", 64'(cmd_bank), 64'd0);
      check("rst_cmd_row", 64'(cmd_row), 64'd0);
      check("rst_cmd_col", 64'(cmd_col), 64'd0);
      check("rst_cmd_time", cmd_time, 64'd0);
      @(posedge clk);
      #1 rst_n = 1;

      issue(0, 2'd0, 34'h0_1234_5678, 0, 0, tr);
      check("read_ready_at_97", tr, 64'd97);
      wait_idle(0, tr);
      issue(0, 2'd1, 34'h0_1234_5678, 0, 0, tr);
      wait_idle(0, tr);
      issue(0, 2'd2, 34'h3_CDEF_0A5C, 0, 0, tr);
      wait_idle(0, tr);
      issue(0, 2'd0, 34'h2_9B3C_7E81, 5, 0, tr);
      wait_idle(0, tr);

      issue(0, 2'd1, 34'h1_0F0F_3C3C, 0, 1, tr);
      repeat (10) @(posedge clk);
      #1 rst_n = 0;
      @(negedge clk);
      check("midrst_req_ready", 64'(req_ready), 64'd0);
      check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check("postrst_req_ready", 64'(req_ready), 64'd1);
      check("postrst_cmd_time", cmd_time, 64'd0);
      check("postrst_sb_empty", 64'(q0.size()), 64'd0);
      nvalid = 0;
      repeat (150) begin
         @(negedge clk);
         if (cmd_valid) nvalid++;
      end
      check("no_cmd_after_reset", 64'(nvalid), 64'd0);

      @(posedge clk);
      #1 rst2_n = 1;
      issue(1, 2'd1, 34'h1_5555_AAAA, 0, 0, tr);
      wait_idle(1, tr);
      issue(1, 2'd0, 34'h0_ABCD_1234, 0, 0, tr);
      wait_idle(1, tr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
